// File: rtl/ioctl_loader_pkg.sv
// Shared types and geometry helpers for the ioctl download loader.
package ioctl_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    HOLD  = 2'd3
  } state_t;

  function automatic int lane_count(input int data_w, input int mem_w);
    return mem_w / data_w;
  endfunction

  function automatic int word_shift(input int mem_w);
    return $clog2(mem_w / 8);
  endfunction

endpackage

// File: rtl/ioctl_pack_word.sv
// Accumulator that merges ioctl beats into one memory word and hands finished words onward.
module ioctl_pack_word
  import ioctl_loader_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int MEM_W   = 32,
  parameter int WADDR_W = 23,
  localparam int LANES  = lane_count(DATA_W, MEM_W),
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               wr_i,
  input  logic [LANE_W-1:0]  lane_i,
  input  logic [WADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]  data_i,
  input  logic               flush_i,
  output logic               push_o,
  output logic [WADDR_W-1:0] push_addr_o,
  output logic [MEM_W-1:0]   push_data_o,
  output logic [LANES-1:0]   push_mask_o,
  output logic               empty_o
);

  logic [WADDR_W-1:0] addr_q, addr_d;
  logic [MEM_W-1:0]   data_q, data_d;
  logic [LANES-1:0]   mask_q, mask_d;
  logic [LANES-1:0]   lane_bit_s, merged_mask_s;
  logic [MEM_W-1:0]   merged_data_s, fresh_data_s;

  always_comb begin
    lane_bit_s = '0;
    lane_bit_s[lane_i] = 1'b1;
    merged_mask_s = mask_q | lane_bit_s;
    merged_data_s = data_q;
    merged_data_s[lane_i*DATA_W +: DATA_W] = data_i;
    fresh_data_s = '0;
    fresh_data_s[lane_i*DATA_W +: DATA_W] = data_i;
  end

  // A write to a new word evicts the partial word and starts a fresh one in the same cycle
  always_comb begin
    addr_d      = addr_q;
    data_d      = data_q;
    mask_d      = mask_q;
    push_o      = 1'b0;
    push_addr_o = addr_q;
    push_data_o = data_q;
    push_mask_o = mask_q;
    if (wr_i) begin
      if ((mask_q != '0) && (addr_q != waddr_i)) begin
        push_o = 1'b1;
        addr_d = waddr_i;
        data_d = fresh_data_s;
        mask_d = lane_bit_s;
      end else if (merged_mask_s == '1) begin
        push_o      = 1'b1;
        push_addr_o = waddr_i;
        push_data_o = merged_data_s;
        push_mask_o = merged_mask_s;
        addr_d      = waddr_i;
        data_d      = '0;
        mask_d      = '0;
      end else begin
        addr_d = waddr_i;
        data_d = merged_data_s;
        mask_d = merged_mask_s;
      end
    end else if (flush_i && (mask_q != '0)) begin
      push_o = 1'b1;
      data_d = '0;
      mask_d = '0;
    end else begin
      mask_d = mask_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addr_q <= '0;
      data_q <= '0;
      mask_q <= '0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      mask_q <= mask_d;
    end
  end

  assign empty_o = (mask_q == '0);

endmodule

// File: rtl/ioctl_loader.sv
// HPS download loader: word packing, region steering, back-pressure and core reset sequencing.
// Define IOCTL_LOADER_CHECKSUM_EN to add the csum_o/csum_valid_o download checksum outputs.
module ioctl_loader
  import ioctl_loader_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int MEM_W       = 32,
  parameter int ADDR_W      = 25,
  parameter int NUM_REGIONS = 2,
  parameter int RESET_HOLD  = 255
) (
  input  logic                                clk_sys_i,
  input  logic                                reset_n_i,
  input  logic                                ioctl_download_i,
  input  logic [7:0]                          ioctl_index_i,
  input  logic                                ioctl_wr_i,
  input  logic [ADDR_W-1:0]                   ioctl_addr_i,
  input  logic [DATA_W-1:0]                   ioctl_dout_i,
  output logic                                ioctl_wait_o,
  output logic [NUM_REGIONS-1:0]              mem_region_o,
  output logic [ADDR_W-word_shift(MEM_W)-1:0] mem_addr_o,
  output logic [MEM_W-1:0]                    mem_data_o,
  output logic [MEM_W/8-1:0]                  mem_be_o,
  output logic                                mem_we_o,
  input  logic                                mem_ready_i,
  output logic                                sys_reset_o,
  output logic                                proto_err_o
`ifdef IOCTL_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]                         csum_o,
  output logic                                csum_valid_o
`endif
);

  localparam int LANES   = lane_count(DATA_W, MEM_W);
  localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int LANE_LO = $clog2(DATA_W / 8);
  localparam int WSHIFT  = word_shift(MEM_W);
  localparam int WADDR_W = ADDR_W - WSHIFT;
  localparam int BPL     = DATA_W / 8;
  localparam int CNT_W   = $clog2(RESET_HOLD + 1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   booted_q, booted_d;
  logic                   sys_reset_q, proto_err_q;
  logic [NUM_REGIONS-1:0] region_q, region_sel_s;
  logic                   out_valid_q;
  logic [NUM_REGIONS-1:0] out_region_q;
  logic [WADDR_W-1:0]     out_addr_q, push_addr_s;
  logic [MEM_W-1:0]       out_data_q, push_data_s;
  logic [MEM_W/8-1:0]     out_be_q, push_be_s;
  logic [LANES-1:0]       push_mask_s;
  logic [LANE_W-1:0]      lane_s;
  logic                   accept_s, flush_s, push_s, acc_empty_s, enter_load_s;

  // Writes are only taken while OUT is free; anything else is a protocol violation
  assign accept_s     = ioctl_wr_i && !out_valid_q && ioctl_download_i && (state_q == LOAD);
  assign flush_s      = (state_q == FLUSH) && !out_valid_q;
  assign enter_load_s = (state_d == LOAD) && (state_q != LOAD);
  assign lane_s       = (LANES > 1) ? LANE_W'(ioctl_addr_i >> LANE_LO) : '0;

  ioctl_pack_word #(
    .DATA_W  (DATA_W),
    .MEM_W   (MEM_W),
    .WADDR_W (WADDR_W)
  ) u_pack (
    .clk_i       (clk_sys_i),
    .rst_n_i     (reset_n_i),
    .wr_i        (accept_s),
    .lane_i      (lane_s),
    .waddr_i     (ioctl_addr_i[ADDR_W-1:WSHIFT]),
    .data_i      (ioctl_dout_i),
    .flush_i     (flush_s),
    .push_o      (push_s),
    .push_addr_o (push_addr_s),
    .push_data_o (push_data_s),
    .push_mask_o (push_mask_s),
    .empty_o     (acc_empty_s)
  );

  always_comb begin
    if (ioctl_index_i >= 8'(NUM_REGIONS - 1)) begin
      region_sel_s = NUM_REGIONS'(1) << (NUM_REGIONS - 1);
    end else begin
      region_sel_s = NUM_REGIONS'(1) << ioctl_index_i;
    end
    push_be_s = '0;
    for (int i = 0; i < LANES; i++) begin
      push_be_s[i*BPL +: BPL] = {BPL{push_mask_s[i]}};
    end
  end

  // FLUSH leaves as soon as OUT drains this cycle so HOLD starts with the bus idle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    booted_d = booted_q;
    case (state_q)
      IDLE: begin
        if (ioctl_download_i) begin
          state_d  = LOAD;
          booted_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (!ioctl_download_i) state_d = FLUSH;
        else                   state_d = LOAD;
      end
      FLUSH: begin
        if (acc_empty_s && (!out_valid_q || mem_ready_i)) begin
          state_d = ioctl_download_i ? LOAD : HOLD;
          cnt_d   = CNT_W'(RESET_HOLD);
        end else begin
          state_d = FLUSH;
        end
      end
      HOLD: begin
        if (ioctl_download_i)            state_d = LOAD;
        else if (cnt_q <= CNT_W'(1))     state_d = IDLE;
        else                             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      booted_q    <= 1'b0;
      sys_reset_q <= 1'b1;
      proto_err_q <= 1'b0;
      region_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      booted_q    <= booted_d;
      sys_reset_q <= !booted_d || (state_d != IDLE);
      proto_err_q <= proto_err_q || (ioctl_wr_i && out_valid_q);
      if (enter_load_s) region_q <= region_sel_s;
    end
  end

  always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      out_valid_q  <= 1'b0;
      out_region_q <= '0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      out_be_q     <= '0;
    end else if (push_s) begin
      out_valid_q  <= 1'b1;
      out_region_q <= region_q;
      out_addr_q   <= push_addr_s;
      out_data_q   <= push_data_s;
      out_be_q     <= push_be_s;
    end else if (out_valid_q && mem_ready_i) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign ioctl_wait_o = out_valid_q;
  assign mem_we_o     = out_valid_q;
  assign mem_region_o = out_region_q;
  assign mem_addr_o   = out_addr_q;
  assign mem_data_o   = out_data_q;
  assign mem_be_o     = out_be_q;
  assign sys_reset_o  = sys_reset_q;
  assign proto_err_o  = proto_err_q;

`ifdef IOCTL_LOADER_CHECKSUM_EN
  logic [15:0] csum_q;
  logic        csum_valid_q;

  always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      csum_q       <= 16'h0000;
      csum_valid_q <= 1'b0;
    end else begin
      if (enter_load_s)  csum_q <= 16'h0000;
      else if (accept_s) csum_q <= csum_q + 16'(ioctl_dout_i);
      csum_valid_q <= booted_d && ((state_d == IDLE) || (state_d == HOLD));
    end
  end

  assign csum_o       = csum_q;
  assign csum_valid_o = csum_valid_q;
`endif

endmodule

// File: tb/tb_ioctl_loader.sv
// Scoreboard bench for ioctl_loader (DATA_W=16, MEM_W=32, RESET_HOLD=4).
module tb_ioctl_loader;

  typedef struct packed {
    logic [1:0]  region;
    logic [22:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n, download, wr, mready;
  logic [7:0]  index;
  logic [24:0] addr;
  logic [15:0] dout;
  logic        wait_s, mwe, sreset, perr;
  logic [1:0]  region;
  logic [22:0] maddr;
  logic [31:0] mdata;
  logic [3:0]  mbe;
`ifdef IOCTL_LOADER_CHECKSUM_EN
  logic [15:0] csum;
  logic        csum_valid;
`endif

  int   checks = 0;
  int   passes = 0;
  bit   rnd_ready = 1'b0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [31:0] mon_bm;

  // reference model state: one pending word, described by byte enables
  logic [22:0] m_addr;
  logic [31:0] m_data;
  logic [3:0]  m_be;
  logic [1:0]  m_region;
  logic [15:0] m_csum;

  ioctl_loader #(
    .DATA_W(16), .MEM_W(32), .ADDR_W(25), .NUM_REGIONS(2), .RESET_HOLD(4)
  ) dut (
    .clk_sys_i        (clk),
    .reset_n_i        (reset_n),
    .ioctl_download_i (download),
    .ioctl_index_i    (index),
    .ioctl_wr_i       (wr),
    .ioctl_addr_i     (addr),
    .ioctl_dout_i     (dout),
    .ioctl_wait_o     (wait_s),
    .mem_region_o     (region),
    .mem_addr_o       (maddr),
    .mem_data_o       (mdata),
    .mem_be_o         (mbe),
    .mem_we_o         (mwe),
    .mem_ready_i      (mready),
    .sys_reset_o      (sreset),
    .proto_err_o      (perr)
`ifdef IOCTL_LOADER_CHECKSUM_EN
    ,
    .csum_o           (csum),
    .csum_valid_o     (csum_valid)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pending();
    exp_t e;
    e.region = m_region;
    e.addr   = m_addr;
    e.data   = m_data;
    e.be     = m_be;
    exp_q.push_back(e);
    m_data = 32'h0;
    m_be   = 4'h0;
  endtask

  task automatic model_write(input logic [24:0] a, input logic [15:0] d);
    int w;
    int hw;
    w  = int'(a) / 4;
    hw = (int'(a) / 2) % 2;
    if (m_be != 4'h0 && 23'(w) != m_addr) push_pending();
    m_addr = 23'(w);
    m_data[hw*16 +: 16] = d;
    m_be = m_be | (4'h3 << (hw * 2));
    m_csum = m_csum + d;
    if (m_be == 4'hF) push_pending();
  endtask

  task automatic do_wr(input logic [24:0] a, input logic [15:0] d);
    int n = 0;
    while (wait_s && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("wr_wait_timeout", {63'b0, wait_s}, 64'd0);
    wr = 1'b1; addr = a; dout = d;
    model_write(a, d);
    tick();
    wr = 1'b0;
  endtask

  task automatic start_download(input logic [7:0] idx);
    index = idx; download = 1'b1;
    m_region = (idx >= 8'd1) ? 2'b10 : 2'b01;
    m_be = 4'h0; m_data = 32'h0; m_csum = 16'h0;
    tick(); tick();
    chk("sys_reset_load", {63'b0, sreset}, 64'd1);
`ifdef IOCTL_LOADER_CHECKSUM_EN
    chk("csum_valid_load", {63'b0, csum_valid}, 64'd0);
`endif
  endtask

  task automatic end_download(input bit check_hold);
    int n = 0;
    int hold = 0;
    download = 1'b0;
    if (m_be != 4'h0) push_pending();
    while ((mwe || exp_q.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    chk("flush_drain", {63'b0, mwe}, 64'd0);
    while (sreset && hold < 300) begin
      hold++;
      tick();
    end
    if (check_hold) chk("hold_cycles", 64'(hold), 64'd4);
    chk("sys_reset_idle", {63'b0, sreset}, 64'd0);
`ifdef IOCTL_LOADER_CHECKSUM_EN
    chk("csum", {48'b0, csum}, {48'b0, m_csum});
    chk("csum_valid", {63'b0, csum_valid}, 64'd1);
`endif
  endtask

  // monitor: every accepted memory write must match the oldest expected word
  always @(negedge clk) begin
    if (reset_n && mwe && mready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {63'b0, mwe}, 64'd0);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_bm = {{8{mon_e.be[3]}}, {8{mon_e.be[2]}}, {8{mon_e.be[1]}}, {8{mon_e.be[0]}}};
        chk("wr_addr", {41'b0, maddr}, {41'b0, mon_e.addr});
        chk("wr_be", {60'b0, mbe}, {60'b0, mon_e.be});
        chk("wr_data", {32'b0, mdata & mon_bm}, {32'b0, mon_e.data & mon_bm});
        chk("wr_region", {62'b0, region}, {62'b0, mon_e.region});
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_ready) mready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [24:0] a;
    logic [31:0] hold_data;
    reset_n = 1'b0; download = 1'b0; wr = 1'b0; mready = 1'b1;
    index = 8'd0; addr = 25'd0; dout = 16'd0;
    m_be = 4'h0; m_data = 32'h0; m_addr = 23'h0; m_region = 2'b00; m_csum = 16'h0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk("rst_wait", {63'b0, wait_s}, 64'd0);
    chk("rst_we", {63'b0, mwe}, 64'd0);
    chk("rst_region", {62'b0, region}, 64'd0);
    chk("rst_addr_data_be", {5'b0, maddr, mdata, mbe}, 64'd0);
    chk("rst_sys_reset", {63'b0, sreset}, 64'd1);
    chk("rst_proto_err", {63'b0, perr}, 64'd0);

    // packing, write latency, odd-length flush, reset hold length
    start_download(8'd0);
    do_wr(25'd0, 16'h1111);
    chk("no_we_half_word", {63'b0, mwe}, 64'd0);
    do_wr(25'd2, 16'h2222);
    chk("lat1_we", {63'b0, mwe}, 64'd1);
    chk("lat1_data", {32'b0, mdata}, 64'h2222_1111);
    chk("lat1_be", {60'b0, mbe}, 64'hF);
    chk("region_idx0", {62'b0, region}, 64'h1);
    chk("wait_pulse", {63'b0, wait_s}, 64'd1);
    do_wr(25'd4, 16'h3333);
    end_download(1'b1);

    // stalled memory: outputs frozen, write during wait flagged
    start_download(8'd7);
    mready = 1'b0;
    do_wr(25'd8, 16'hAAAA);
    do_wr(25'd10, 16'hBBBB);
    hold_data = mdata;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) wr = 1'b1;
      addr = 25'd12; dout = 16'hDEAD;
      tick();
      wr = 1'b0;
      chk("stall_wait", {63'b0, wait_s}, 64'd1);
      chk("stall_addr", {41'b0, maddr}, 64'd2);
      chk("stall_data", {32'b0, mdata}, {32'b0, hold_data});
    end
    chk("proto_err_set", {63'b0, perr}, 64'd1);
    chk("region_idx7", {62'b0, region}, 64'h2);
    mready = 1'b1;
    do_wr(25'd12, 16'h4444);
    do_wr(25'd14, 16'h5555);
    end_download(1'b0);
    chk("proto_err_sticky", {63'b0, perr}, 64'd1);

    // checksum wrap
    start_download(8'd1);
    do_wr(25'd0, 16'hFFFF);
    do_wr(25'd2, 16'h0002);
    end_download(1'b0);

    // reset mid-word discards the partial word
    start_download(8'd0);
    do_wr(25'd20, 16'h7777);
    reset_n = 1'b0; download = 1'b0;
    m_be = 4'h0; m_data = 32'h0;
    tick();
    chk("midrst_sys_reset", {63'b0, sreset}, 64'd1);
    chk("midrst_proto_err", {63'b0, perr}, 64'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrst_no_we", {63'b0, mwe}, 64'd0);
    end
    chk("midrst_sys_reset_hold", {63'b0, sreset}, 64'd1);

    // randomized downloads with random back-pressure
    rnd_ready = 1'b1;
    for (int d = 0; d < 6; d++) begin
      start_download(8'($urandom_range(0, 9)));
      a = 25'($urandom_range(0, 63) * 2);
      for (int k = 0; k < int'($urandom_range(1, 14)); k++) begin
        int r;
        do_wr(a, 16'($urandom));
        r = $urandom_range(0, 9);
        if (r < 6)      a = a + 25'd2;
        else if (r < 8) a = 25'($urandom_range(0, 63) * 2);
        else            a = a;
      end
      end_download(1'b0);
    end
    rnd_ready = 1'b0;
    mready = 1'b1;
    tick(); tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
